// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: aligns to a frame-sync pulse, assembles MSB-first
// WIDTH-bit words and hands them off through a one-entry valid/ready holding register.
module serial_deserializer #(
  parameter int WIDTH        = 8,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_sync,
  input  logic                     i_bit_valid,
  input  logic                     i_serial_in,
  output logic [WIDTH-1:0]         o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr,
  output logic                     o_aligned,
  output logic [$clog2(WIDTH)-1:0] o_bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam state_t RESET_STATE = REQUIRE_SYNC ? HUNT : RECV;

  state_t           r_state;
  // Only WIDTH-1 bits are ever needed: the last bit of a word goes straight to the output.
  logic [WIDTH-2:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overflow;

  logic             w_in_recv;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic             w_consume;
  logic [WIDTH-2:0] w_shreg_next;
  logic [WIDTH-1:0] w_word;

  generate
    if (WIDTH == 2) begin : g_shreg_w2
      assign w_shreg_next = i_serial_in;
    end else begin : g_shreg_wn
      assign w_shreg_next = {r_shreg[WIDTH-3:0], i_serial_in};
    end
  endgenerate

  assign w_in_recv  = (r_state == RECV);
  assign w_accept   = i_bit_valid & (w_in_recv | i_sync);
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  // Sync always wins over completion: a sync on the final bit restarts the word.
  assign w_complete = w_accept & ~i_sync & w_last_bit;
  assign w_word     = {r_shreg, i_serial_in};
  assign w_load     = w_complete & (~r_out_valid | i_out_ready);
  assign w_drop     = w_complete & r_out_valid & ~i_out_ready;
  assign w_consume  = r_out_valid & i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        HUNT: begin
          if (i_sync) begin
            r_state <= RECV;
          end
        end
        RECV: begin
          r_state <= RECV;
        end
        default: begin
          r_state <= RESET_STATE;
        end
      endcase

      if (w_accept) begin
        r_shreg <= w_shreg_next;
      end

      if (i_sync) begin
        r_bit_cnt <= i_bit_valid ? CW'(1) : '0;
      end else if (w_accept) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CW'(1);
      end

      if (w_load) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overflow  = r_overflow;
  assign o_aligned   = w_in_recv;
  assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed plus randomized bench for serial_deserializer (WIDTH=8, REQUIRE_SYNC=1)
// against a word-level reference model of framing and the one-slot output buffer.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_sync = 1'b0;
  logic             i_bit_valid = 1'b0;
  logic             i_serial_in = 1'b0;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             i_out_ready = 1'b0;
  logic             o_overflow;
  logic             i_overflow_clr = 1'b0;
  logic             o_aligned;
  logic [CW-1:0]    o_bit_cnt;

  always #5 clk = ~clk;

  serial_deserializer #(
    .WIDTH       (WIDTH),
    .REQUIRE_SYNC(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sync        (i_sync),
    .i_bit_valid   (i_bit_valid),
    .i_serial_in   (i_serial_in),
    .o_out_data    (o_out_data),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_overflow    (o_overflow),
    .i_overflow_clr(i_overflow_clr),
    .o_aligned     (o_aligned),
    .o_bit_cnt     (o_bit_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: framing tracked as a bit count and an integer accumulator.
  bit               m_aligned;
  int               m_len;
  int unsigned      m_acc;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ovf;

  task automatic model_reset();
    m_aligned = 1'b0;
    m_len     = 0;
    m_acc     = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic bv, input logic b,
                            input logic rdy, input logic clr);
    bit               done;
    bit               drop;
    logic [WIDTH-1:0] word;
    done = 1'b0;
    word = '0;
    if (s) begin
      m_aligned = 1'b1;
      m_len     = bv ? 1 : 0;
      m_acc     = (bv && b) ? 1 : 0;
    end else if (m_aligned && bv) begin
      m_acc = m_acc * 2 + (b ? 1 : 0);
      m_len = m_len + 1;
      if (m_len == WIDTH) begin
        done  = 1'b1;
        word  = WIDTH'(m_acc);
        m_len = 0;
        m_acc = 0;
      end
    end
    drop = done && m_valid && !rdy;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (done && !drop) begin
      m_data  = word;
      m_valid = 1'b1;
      $display("word %02h delivered", word);
    end else if (done) begin
      $display("word %02h dropped (holding register full)", word);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},    64'(o_out_data),  64'(m_data));
    chk({tag, ".valid"},   64'(o_out_valid), 64'(m_valid));
    chk({tag, ".ovf"},     64'(o_overflow),  64'(m_ovf));
    chk({tag, ".aligned"}, 64'(o_aligned),   64'(m_aligned));
    chk({tag, ".bit_cnt"}, 64'(o_bit_cnt),   64'(m_len));
  endtask

  task automatic step(input string tag, input logic s, input logic bv, input logic b,
                      input logic rdy, input logic clr);
    i_sync         = s;
    i_bit_valid    = bv;
    i_serial_in    = b;
    i_out_ready    = rdy;
    i_overflow_clr = clr;
    @(posedge clk);
    model_edge(s, bv, b, rdy, clr);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [WIDTH-1:0] w,
                           input logic with_sync, input logic rdy_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(tag, with_sync && (i == WIDTH - 1), 1'b1, w[i], (i == 0) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    model_reset();
    #2;
    check_all("reset");
    #10;
    rst_n = 1'b1;

    // Bits before the first sync are ignored.
    for (int i = 0; i < 3; i++) step("hunt", 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("hunt_cnt", 64'(o_bit_cnt), 64'd0);
    step("a5_sync", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("a5_aligned", 64'(o_aligned), 64'd1);
    w = 8'hA5;
    for (int i = WIDTH - 2; i >= 0; i--) step("a5", 1'b0, 1'b1, w[i], 1'b0, 1'b0);
    chk("a5_data", 64'(o_out_data), 64'hA5);
    chk("a5_valid", 64'(o_out_valid), 64'd1);

    // Consume and complete on the same edge: no bubble.
    send_word("w3c", 8'h3C, 1'b0, 1'b1);
    chk("3c_data", 64'(o_out_data), 64'h3C);
    chk("3c_valid", 64'(o_out_valid), 64'd1);
    send_word("wc3", 8'hC3, 1'b0, 1'b1);
    chk("c3_data", 64'(o_out_data), 64'hC3);
    chk("c3_valid", 64'(o_out_valid), 64'd1);
    chk("c3_ovf", 64'(o_overflow), 64'd0);

    // Stalled consumer: second word dropped, overflow sticky until cleared.
    step("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("w11", 8'h11, 1'b0, 1'b0);
    send_word("w22", 8'h22, 1'b0, 1'b0);
    chk("ovf_data", 64'(o_out_data), 64'h11);
    chk("ovf_set", 64'(o_overflow), 64'd1);
    step("ovf_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);
    step("ovf_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    step("consume11", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("consume11_valid", 64'(o_out_valid), 64'd0);
    chk("consume11_data", 64'(o_out_data), 64'h11);

    // Mid-word realign.
    for (int i = 0; i < 5; i++) step("junk", 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("junk_cnt", 64'(o_bit_cnt), 64'd5);
    step("f0_sync", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("realign_cnt", 64'(o_bit_cnt), 64'd1);
    w = 8'hF0;
    for (int i = WIDTH - 2; i >= 0; i--) step("f0", 1'b0, 1'b1, w[i], 1'b0, 1'b0);
    chk("f0_data", 64'(o_out_data), 64'hF0);
    chk("f0_ovf", 64'(o_overflow), 64'd0);
    step("consume_f0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped strobes.
    w = 8'h81;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step("g81", i == WIDTH - 1, 1'b1, w[i], 1'b0, 1'b0);
      step("g81_gap", 1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
    end
    chk("g81_data", 64'(o_out_data), 64'h81);
    step("consume_81", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sync on the WIDTH-th bit restarts instead of completing.
    for (int i = 0; i < WIDTH - 1; i++) step("pre_sync", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("late_sync", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("late_sync_valid", 64'(o_out_valid), 64'd0);
    chk("late_sync_cnt", 64'(o_bit_cnt), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(19, 0) == 0), ($urandom_range(3, 0) != 0), 1'($urandom),
           1'($urandom), ($urandom_range(7, 0) == 0));
    end

    // Asynchronous reset mid-word with a held word.
    step("pre_rst_drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("w5a", 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("mid", 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("pre_rst_cnt", 64'(o_bit_cnt), 64'd4);
    chk("pre_rst_valid", 64'(o_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_aligned", 64'(o_aligned), 64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("post_rst", 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("post_rst_cnt", 64'(o_bit_cnt), 64'd0);
    send_word("w96", 8'h96, 1'b1, 1'b0);
    chk("post_rst_data", 64'(o_out_data), 64'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
